// File: rtl/mlp_argmax_scorer.sv
// Classification back end: snapshots a score vector, scans it one lane per cycle
// for the signed argmax, compares with the label and keeps saturating statistics.
module mlp_argmax_scorer #(
  parameter int N_CLASS = 10,
  parameter int DW      = 16,
  parameter int LBL_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [N_CLASS*DW-1:0]   scores_i,
  input  logic [LBL_W-1:0]        label_i,
  input  logic                    clear_stats_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LBL_W-1:0]        class_o,
  output logic [DW-1:0]           max_o,
  output logic                    match_o,
  output logic [CNT_W-1:0]        img_cnt_o,
  output logic [CNT_W-1:0]        correct_cnt_o
);

  localparam int KW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam logic [KW-1:0] KMAX = KW'(N_CLASS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [N_CLASS*DW-1:0]   snap_q, snap_d;
  logic [LBL_W-1:0]        label_q, label_d;
  logic [LBL_W-1:0]        idx_q, idx_d;
  logic [LBL_W-1:0]        class_q, class_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [DW-1:0]    max_q, max_d;
  logic signed [DW-1:0]    maxo_q, maxo_d;
  logic                    match_q, match_d;
  logic [CNT_W-1:0]        img_q, img_d;
  logic [CNT_W-1:0]        cor_q, cor_d;

  logic signed [DW-1:0]    lane_k;
  logic signed [DW-1:0]    fin_max;
  logic [LBL_W-1:0]        fin_idx;
  logic                    better;

  always_comb begin
    lane_k  = snap_q[DW*int'(k_q) +: DW];
    better  = lane_k > max_q;
    fin_idx = better ? LBL_W'(k_q) : idx_q;
    fin_max = better ? lane_k : max_q;

    state_d = state_q;
    snap_d  = snap_q;
    label_d = label_q;
    idx_d   = idx_q;
    k_d     = k_q;
    max_d   = max_q;
    class_d = class_q;
    maxo_d  = maxo_q;
    match_d = match_q;
    img_d   = img_q;
    cor_d   = cor_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          snap_d  = scores_i;
          label_d = label_i;
          max_d   = scores_i[DW-1:0];
          idx_d   = '0;
          k_d     = KW'(1);
          if (N_CLASS == 1) begin
            state_d = S_DONE;
            class_d = '0;
            maxo_d  = scores_i[DW-1:0];
            match_d = (label_i == '0);
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        max_d = fin_max;
        idx_d = fin_idx;
        // Results are loaded on the final compare so they are valid while done_o is high.
        if (k_q == KMAX) begin
          state_d = S_DONE;
          class_d = fin_idx;
          maxo_d  = fin_max;
          match_d = (fin_idx == label_q);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Statistics update as DONE retires; a clear in that cycle takes precedence.
    if (clear_stats_i) begin
      img_d = '0;
      cor_d = '0;
    end else if (state_q == S_DONE) begin
      if (img_q != '1) img_d = img_q + 1'b1;
      if (match_q && (cor_q != '1)) cor_d = cor_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      label_q <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      max_q   <= '0;
      class_q <= '0;
      maxo_q  <= '0;
      match_q <= 1'b0;
      img_q   <= '0;
      cor_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      label_q <= label_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      max_q   <= max_d;
      class_q <= class_d;
      maxo_q  <= maxo_d;
      match_q <= match_d;
      img_q   <= img_d;
      cor_q   <= cor_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign class_o       = class_q;
  assign max_o         = maxo_q;
  assign match_o       = match_q;
  assign img_cnt_o     = img_q;
  assign correct_cnt_o = cor_q;

endmodule

// File: tb/tb_mlp_argmax_scorer.sv
// Directed bench for mlp_argmax_scorer: argmax, ties, signed compare, busy
// start rejection, label range, stats clear, mid-scan reset and counter saturation.
module tb_mlp_argmax_scorer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start = 1'b0;
  logic [159:0] scores = '0;
  logic [3:0]   label = '0;
  logic         clear = 1'b0;
  logic         busy, done, match;
  logic [3:0]   cls;
  logic [15:0]  mx;
  logic [15:0]  img, cor;

  logic         s_start = 1'b0;
  logic [159:0] s_scores = '0;
  logic [3:0]   s_label = '0;
  logic         s_clear = 1'b0;
  logic         s_busy, s_done, s_match;
  logic [3:0]   s_cls;
  logic [15:0]  s_mx;
  logic [1:0]   s_img, s_cor;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mlp_argmax_scorer #(.N_CLASS(10), .DW(16), .LBL_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .scores_i(scores), .label_i(label),
    .clear_stats_i(clear), .busy_o(busy), .done_o(done), .class_o(cls),
    .max_o(mx), .match_o(match), .img_cnt_o(img), .correct_cnt_o(cor)
  );

  mlp_argmax_scorer #(.N_CLASS(10), .DW(16), .LBL_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start_i(s_start), .scores_i(s_scores), .label_i(s_label),
    .clear_stats_i(s_clear), .busy_o(s_busy), .done_o(s_done), .class_o(s_cls),
    .max_o(s_mx), .match_o(s_match), .img_cnt_o(s_img), .correct_cnt_o(s_cor)
  );

  function automatic logic [159:0] fill(input logic [15:0] v);
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  // Drives one start pulse, scrambles scores_i afterwards, returns cycles to done_o (0 = timeout).
  task automatic run_image(input logic [159:0] sc, input logic [3:0] lb, output int lat);
    @(negedge clk);
    start = 1'b1; scores = sc; label = lb;
    @(negedge clk);
    start = 1'b0; scores = fill(16'h1234); label = 4'hF;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (cls !== 4'd0)   begin bad++; $display("FAIL reset_class got=%0d exp=0", cls); end
    total++; if (mx !== 16'd0)   begin bad++; $display("FAIL reset_max got=%h exp=0000", mx); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%0b exp=0", match); end
    total++; if (img !== 16'd0 || cor !== 16'd0)
      begin bad++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", img, cor); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || s_busy !== 1'b0)
      begin bad++; $display("FAIL post_reset_busy got=%0b/%0b exp=0/0", busy, s_busy); end
  endtask

  task automatic test_basic;
    logic [159:0] sc;
    int lat;
    sc = fill(16'hFFEC);
    sc[3*16 +: 16] = 16'd500;
    run_image(sc, 4'd3, lat);
    total++; if (lat !== 10)      begin bad++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    total++; if (cls !== 4'd3)    begin bad++; $display("FAIL basic_class got=%0d exp=3", cls); end
    total++; if (mx !== 16'd500)  begin bad++; $display("FAIL basic_max got=%h exp=01f4", mx); end
    total++; if (match !== 1'b1)  begin bad++; $display("FAIL basic_match got=%0b exp=1", match); end
    total++; if (busy !== 1'b1)   begin bad++; $display("FAIL basic_busy_in_done got=%0b exp=1", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
    total++; if (img !== 16'd1 || cor !== 16'd1)
      begin bad++; $display("FAIL basic_cnts got=%0d/%0d exp=1/1", img, cor); end
  endtask

  task automatic test_tie;
    int lat;
    run_image(fill(16'hFFF9), 4'd5, lat);
    total++; if (lat !== 10)       begin bad++; $display("FAIL tie_latency got=%0d exp=10", lat); end
    total++; if (cls !== 4'd0)     begin bad++; $display("FAIL tie_class got=%0d exp=0", cls); end
    total++; if (mx !== 16'hFFF9)  begin bad++; $display("FAIL tie_max got=%h exp=fff9", mx); end
    total++; if (match !== 1'b0)   begin bad++; $display("FAIL tie_match got=%0b exp=0", match); end
    @(negedge clk);
    total++; if (img !== 16'd2 || cor !== 16'd1)
      begin bad++; $display("FAIL tie_cnts got=%0d/%0d exp=2/1", img, cor); end
  endtask

  task automatic test_signed;
    logic [159:0] sc;
    int lat;
    sc = fill(16'h0000);
    sc[9*16 +: 16] = 16'h7FFF;
    sc[0*16 +: 16] = 16'h8000;
    run_image(sc, 4'd9, lat);
    total++; if (cls !== 4'd9)     begin bad++; $display("FAIL signed_class got=%0d exp=9", cls); end
    total++; if (mx !== 16'h7FFF)  begin bad++; $display("FAIL signed_max got=%h exp=7fff", mx); end
    total++; if (match !== 1'b1)   begin bad++; $display("FAIL signed_match got=%0b exp=1", match); end
    @(negedge clk);
    total++; if (img !== 16'd3 || cor !== 16'd2)
      begin bad++; $display("FAIL signed_cnts got=%0d/%0d exp=3/2", img, cor); end
  endtask

  task automatic test_busy_start;
    logic [159:0] sa, sb;
    int ndone, first;
    logic [3:0] c0;
    logic [15:0] m0;
    logic mt0;
    sa = fill(16'h0000);
    sa[6*16 +: 16] = 16'd100;
    sb = fill(16'h0000);
    sb[2*16 +: 16] = 16'd900;
    ndone = 0; first = 0; c0 = '0; m0 = '0; mt0 = 1'b0;
    @(negedge clk);
    start = 1'b1; scores = sa; label = 4'd6;
    @(negedge clk);
    start = 1'b0; scores = sb;
    for (int n = 1; n <= 25; n++) begin
      if (done) begin
        ndone++;
        if (first == 0) begin first = n; c0 = cls; m0 = mx; mt0 = match; end
      end
      if (n == 3) begin start = 1'b1; scores = sb; label = 4'd2; end
      if (n == 4) begin start = 1'b0; scores = fill(16'h7000); end
      @(negedge clk);
    end
    total++; if (ndone !== 1)      begin bad++; $display("FAIL busy_start_ndone got=%0d exp=1", ndone); end
    total++; if (first !== 10)     begin bad++; $display("FAIL busy_start_latency got=%0d exp=10", first); end
    total++; if (c0 !== 4'd6)      begin bad++; $display("FAIL busy_start_class got=%0d exp=6", c0); end
    total++; if (m0 !== 16'd100)   begin bad++; $display("FAIL busy_start_max got=%h exp=0064", m0); end
    total++; if (mt0 !== 1'b1)     begin bad++; $display("FAIL busy_start_match got=%0b exp=1", mt0); end
    total++; if (img !== 16'd4 || cor !== 16'd3)
      begin bad++; $display("FAIL busy_start_cnts got=%0d/%0d exp=4/3", img, cor); end
  endtask

  task automatic test_label_range;
    logic [159:0] sc;
    int lat;
    sc = fill(16'h0000);
    sc[4*16 +: 16] = 16'd300;
    run_image(sc, 4'd12, lat);
    total++; if (cls !== 4'd4)     begin bad++; $display("FAIL oob_class got=%0d exp=4", cls); end
    total++; if (match !== 1'b0)   begin bad++; $display("FAIL oob_match got=%0b exp=0", match); end
    @(negedge clk);
    total++; if (img !== 16'd5 || cor !== 16'd3)
      begin bad++; $display("FAIL oob_cnts got=%0d/%0d exp=5/3", img, cor); end
  endtask

  task automatic test_clear_and_reset;
    logic [159:0] sc;
    int lat, ndone;
    sc = fill(16'h0000);
    sc[1*16 +: 16] = 16'd50;
    run_image(sc, 4'd1, lat);
    total++; if (lat !== 10)       begin bad++; $display("FAIL clear_latency got=%0d exp=10", lat); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (img !== 16'd0 || cor !== 16'd0)
      begin bad++; $display("FAIL clear_cnts got=%0d/%0d exp=0/0", img, cor); end
    total++; if (cls !== 4'd1 || mx !== 16'd50 || match !== 1'b1)
      begin bad++; $display("FAIL clear_result got=%0d/%h/%0b exp=1/0032/1", cls, mx, match); end

    sc = fill(16'h0000);
    sc[4*16 +: 16] = 16'd10;
    @(negedge clk);
    start = 1'b1; scores = sc; label = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midscan_rst_busy got=%0b exp=0", busy); end
    total++; if (cls !== 4'd0 || mx !== 16'd0 || match !== 1'b0)
      begin bad++; $display("FAIL midscan_rst_outputs got=%0d/%h/%0b exp=0/0000/0", cls, mx, match); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    total++; if (ndone !== 0)      begin bad++; $display("FAIL midscan_rst_done got=%0d exp=0", ndone); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midscan_rst_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_saturate;
    logic [159:0] sc;
    logic [1:0] exp_c;
    int lat;
    sc = fill(16'hFF00);
    sc[2*16 +: 16] = 16'd1000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      s_start = 1'b1; s_scores = sc; s_label = 4'd2;
      @(negedge clk);
      s_start = 1'b0; s_scores = '0;
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
        if (s_done) begin lat = n; break; end
        @(negedge clk);
      end
      total++; if (lat !== 10) begin bad++; $display("FAIL sat_latency_%0d got=%0d exp=10", i, lat); end
      @(negedge clk);
      exp_c = (i >= 3) ? 2'd3 : 2'(i);
      total++; if (s_img !== exp_c || s_cor !== exp_c)
        begin bad++; $display("FAIL sat_cnts_%0d got=%0d/%0d exp=%0d/%0d", i, s_img, s_cor, exp_c, exp_c); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_signed();
    test_busy_start();
    test_label_range();
    test_clear_and_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
